// File: rtl/song_timer_pkg.sv
// Shared types and sizing helpers for the song timer.
package song_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int POS_W_DEFAULT          = 16;
  localparam int TPS_W_DEFAULT          = 16;
  localparam int STEPS_PER_BEAT_DEFAULT = 4;

  // A single-step beat still needs a 1-bit counter to keep the vector legal.
  function automatic int beat_cnt_width(input int steps_per_beat);
    return (steps_per_beat > 1) ? $clog2(steps_per_beat) : 1;
  endfunction

endpackage

// File: rtl/song_timer_tick_edge_detect.sv
// Rising-edge pulse generator for the divided tick level.
// Define TICK_SYNC_EN to insert a 2-flop synchroniser ahead of the edge detect.
module tick_edge_detect
  import song_timer_pkg::*;
(
  input  logic clock_104mhz,
  input  logic reset_n,
  input  logic tick_in,
  output logic tick_pulse
);

  logic tick_s;
  logic tick_d_reg;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clock_104mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], tick_in};
    end
  end

  assign tick_s = sync_reg[1];
`else
  // Divider output is already in this clock domain, so no synchroniser.
  assign tick_s = tick_in;
`endif

  always_ff @(posedge clock_104mhz or negedge reset_n) begin
    if (!reset_n) begin
      tick_d_reg <= 1'b0;
    end else begin
      tick_d_reg <= tick_s;
    end
  end

  assign tick_pulse = tick_s & ~tick_d_reg;

endmodule

// File: rtl/song_timer.sv
// Song-time generator: counts tick edges into steps and beats under start/pause/stop control.
// Optional macro TICK_SYNC_EN (handled in tick_edge_detect) adds a 2-flop tick synchroniser.
module song_timer
  import song_timer_pkg::*;
#(
  parameter int POS_W          = POS_W_DEFAULT,
  parameter int STEPS_PER_BEAT = STEPS_PER_BEAT_DEFAULT,
  parameter int TPS_W          = TPS_W_DEFAULT
) (
  input  logic             clock_104mhz,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic [TPS_W-1:0] ticks_per_step,
  input  logic [POS_W-1:0] song_length,
  output logic [POS_W-1:0] position,
  output logic             step_strobe,
  output logic             beat_strobe,
  output logic             running,
  output logic             done
);

  localparam int                BEAT_W    = beat_cnt_width(STEPS_PER_BEAT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(STEPS_PER_BEAT - 1);

  logic tick_pulse;

  tick_edge_detect u_tick_edge_detect (
    .clock_104mhz (clock_104mhz),
    .reset_n      (reset_n),
    .tick_in      (tick_in),
    .tick_pulse   (tick_pulse)
  );

  state_t            state_reg, state_next;
  logic [TPS_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [TPS_W-1:0]  tps_reg, tps_next;
  logic [POS_W-1:0]  pos_reg, pos_next;
  logic [POS_W-1:0]  len_reg, len_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic              step_reg, step_next;
  logic              beat_reg, beat_next;
  logic              launch;

  always_ff @(posedge clock_104mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      tps_reg      <= '0;
      pos_reg      <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      step_reg     <= 1'b0;
      beat_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      tps_reg      <= tps_next;
      pos_reg      <= pos_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      step_reg     <= step_next;
      beat_reg     <= beat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    tps_next      = tps_reg;
    pos_next      = pos_reg;
    len_next      = len_reg;
    beat_cnt_next = beat_cnt_reg;
    step_next     = 1'b0;
    beat_next     = 1'b0;
    launch        = 1'b0;

    if (stop) begin
      state_next    = ST_IDLE;
      tick_cnt_next = '0;
      pos_next      = '0;
      beat_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!pause && start) launch = 1'b1;
        end
        ST_RUNNING: begin
          // Pause outranks a tick arriving in the same cycle.
          if (pause) begin
            state_next = ST_PAUSED;
          end else if (tick_pulse) begin
            if (tick_cnt_reg == tps_reg - TPS_W'(1)) begin
              tick_cnt_next = '0;
              step_next     = 1'b1;
              if (beat_cnt_reg == BEAT_LAST) begin
                beat_cnt_next = '0;
                beat_next     = 1'b1;
              end else begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
              end
              if (pos_reg == len_reg - POS_W'(1)) begin
                state_next = ST_DONE;
              end else begin
                pos_next = pos_reg + POS_W'(1);
              end
            end else begin
              tick_cnt_next = tick_cnt_reg + TPS_W'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause && start) state_next = ST_RUNNING;
        end
        ST_DONE: begin
          if (start) launch = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    if (launch) begin
      tps_next      = (ticks_per_step == '0) ? TPS_W'(1) : ticks_per_step;
      len_next      = song_length;
      tick_cnt_next = '0;
      pos_next      = '0;
      beat_cnt_next = '0;
      state_next    = (song_length == '0) ? ST_DONE : ST_RUNNING;
    end
  end

  assign position    = pos_reg;
  assign step_strobe = step_reg;
  assign beat_strobe = beat_reg;
  assign running     = (state_reg == ST_RUNNING);
  assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_song_timer.sv
// Bench for song_timer: step-count reference model checked every cycle, plus directed scenarios.
module tb_song_timer;

  localparam int POS_W = 16;
  localparam int TPS_W = 16;
  localparam int SPB   = 4;
`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             tick_in, start, pause, stop;
  logic [TPS_W-1:0] ticks_per_step;
  logic [POS_W-1:0] song_length;
  logic [POS_W-1:0] position;
  logic             step_strobe, beat_strobe, running, done;

  int checks = 0;
  int errors = 0;

  song_timer #(.POS_W(POS_W), .STEPS_PER_BEAT(SPB), .TPS_W(TPS_W)) dut (
    .clock_104mhz   (clk),
    .reset_n        (reset_n),
    .tick_in        (tick_in),
    .start          (start),
    .pause          (pause),
    .stop           (stop),
    .ticks_per_step (ticks_per_step),
    .song_length    (song_length),
    .position       (position),
    .step_strobe    (step_strobe),
    .beat_strobe    (beat_strobe),
    .running        (running),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, k = steps completed, e = tick edges into the current step.
  int m_mode = M_IDLE, m_k = 0, m_e = 0, m_tps = 0, m_len = 0;
  bit m_prev = 0, m_s1 = 0, m_s2 = 0;
  bit exp_step = 0, exp_beat = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int mode, k, e, tps, len;
    bit ts, pulse, stp, bt, launch;
    if (!reset_n) begin
      m_mode <= M_IDLE; m_k <= 0; m_e <= 0; m_tps <= 0; m_len <= 0;
      m_prev <= 0; m_s1 <= 0; m_s2 <= 0; exp_step <= 0; exp_beat <= 0;
    end else begin
      mode = m_mode; k = m_k; e = m_e; tps = m_tps; len = m_len;
`ifdef TICK_SYNC_EN
      ts = m_s2;
`else
      ts = tick_in;
`endif
      pulse = ts && !m_prev;
      stp = 0; bt = 0; launch = 0;
      if (stop) begin
        mode = M_IDLE; k = 0; e = 0;
      end else begin
        case (mode)
          M_IDLE:  if (!pause && start) launch = 1;
          M_DONE:  if (start) launch = 1;
          M_PAUSE: if (!pause && start) mode = M_RUN;
          default: begin
            if (pause) mode = M_PAUSE;
            else if (pulse) begin
              e++;
              if (e == tps) begin
                e = 0; k++; stp = 1;
                bt = (k % SPB) == 0;
                if (k == len) mode = M_DONE;
              end
            end
          end
        endcase
      end
      if (launch) begin
        tps = (ticks_per_step == 0) ? 1 : int'(ticks_per_step);
        len = int'(song_length);
        k = 0; e = 0;
        mode = (len == 0) ? M_DONE : M_RUN;
      end
      m_mode <= mode; m_k <= k; m_e <= e; m_tps <= tps; m_len <= len;
      m_prev <= ts; m_s2 <= m_s1; m_s1 <= tick_in;
      exp_step <= stp; exp_beat <= bt;
    end
  end

  always @(negedge clk) begin
    int exp_pos;
    exp_pos = (m_k == 0) ? 0 : ((m_k < m_len) ? m_k : m_len - 1);
    chk("position", 32'(position), exp_pos);
    chk("step_strobe", 32'(step_strobe), 32'(exp_step));
    chk("beat_strobe", 32'(beat_strobe), 32'(exp_beat));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("done", 32'(done), 32'(m_mode == M_DONE));
  end

  // Strobe tallies for the directed scenarios; beat_at records the step count at each beat.
  int step_seen = 0, beat_seen = 0;
  int beat_at [1024];
  always @(negedge clk) begin
    if (step_strobe) step_seen <= step_seen + 1;
    if (beat_strobe) begin
      beat_at[beat_seen % 1024] <= step_seen + (step_strobe ? 1 : 0);
      beat_seen <= beat_seen + 1;
    end
  end

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick_in = 1'b1;
      @(negedge clk);
      @(negedge clk); tick_in = 1'b0;
      @(negedge clk);
    end
    #2;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #2;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  int bs, bb;

  initial begin
    reset_n = 1'b1; tick_in = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    ticks_per_step = '0; song_length = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_position", 32'(position), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_done", 32'(done), 0);
    @(negedge clk); reset_n = 1'b1;

    // Full song: 24 edges at 3 per step over 8 steps.
    ticks_per_step = 3; song_length = 8;
    pulse_start();
    bs = step_seen; bb = beat_seen;
    edges(24);
    chk("t1_steps", 32'(step_seen - bs), 8);
    chk("t1_beats", 32'(beat_seen - bb), 2);
    chk("t1_beat0_step", 32'(beat_at[bb] - bs), 4);
    chk("t1_beat1_step", 32'(beat_at[bb + 1] - bs), 8);
    chk("t1_position", 32'(position), 7);
    chk("t1_done", 32'(done), 1);

    // tps=0 is treated as 1; restart straight from DONE.
    ticks_per_step = 0; song_length = 2;
    pulse_start();
    bs = step_seen;
    edges(2);
    chk("t2_steps", 32'(step_seen - bs), 2);
    chk("t2_done", 32'(done), 1);
    chk("t2_position", 32'(position), 1);

    // Latency from the completing tick sample to step_strobe.
    ticks_per_step = 1; song_length = 4;
    pulse_start();
    @(negedge clk); tick_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      chk("latency", 32'(step_strobe), 32'(i == LAT));
    end
    @(negedge clk); tick_in = 1'b0;
    pulse_stop();

    // Pause mid-step with tick held high.
    ticks_per_step = 3; song_length = 10;
    pulse_start();
    bs = step_seen;
    @(negedge clk); tick_in = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tick_in = 1'b0; repeat (2) @(negedge clk);
      tick_in = 1'b1; repeat (2) @(negedge clk);
    end
    #2;
    chk("pause_steps", 32'(step_seen - bs), 0);
    chk("pause_running", 32'(running), 0);
    @(negedge clk); pause = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("resume_running", 32'(running), 1);
    chk("resume_no_spurious", 32'(step_seen - bs), 0);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    edges(1);
    chk("resume_edge1", 32'(step_seen - bs), 0);
    edges(1);
    chk("resume_edge2", 32'(step_seen - bs), 1);
    chk("resume_position", 32'(position), 1);
    pulse_stop();

    // stop and start together while RUNNING at position 5.
    ticks_per_step = 1; song_length = 20;
    pulse_start();
    edges(5);
    chk("t4_position", 32'(position), 5);
    @(negedge clk); stop = 1'b1; start = 1'b1; tick_in = 1'b1;
    @(posedge clk); #1;
    chk("t4_running", 32'(running), 0);
    chk("t4_position0", 32'(position), 0);
    chk("t4_no_strobe", 32'(step_strobe), 0);
    @(negedge clk); stop = 1'b0; start = 1'b0; tick_in = 1'b0;

    // Zero-length song goes straight to DONE.
    ticks_per_step = 2; song_length = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("t5_done", 32'(done), 1);
    chk("t5_position", 32'(position), 0);
    chk("t5_no_strobe", 32'(step_strobe), 0);
    @(negedge clk); start = 1'b0;
    pulse_stop();

    // Asynchronous reset in the middle of a step.
    ticks_per_step = 3; song_length = 10;
    pulse_start();
    edges(4);
    chk("t6_position", 32'(position), 1);
    @(negedge clk); tick_in = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_position", 32'(position), 0);
    chk("t6_rst_step", 32'(step_strobe), 0);
    chk("t6_rst_beat", 32'(beat_strobe), 0);
    chk("t6_rst_running", 32'(running), 0);
    chk("t6_rst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1; tick_in = 1'b0;

    // Randomised run; the per-cycle compare process does the checking.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      start = ($urandom_range(0, 19) == 0);
      pause = pause ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      ticks_per_step = TPS_W'($urandom_range(0, 3));
      song_length    = POS_W'($urandom_range(0, 12));
    end
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/song_timer.md
Name: song_timer

Overview:
- Consumes the slow divided tick level produced by the clock divider and turns it into song-time for the note highway.
- Edge-detects the tick and counts a programmable number of ticks per step.
- Advances a song position counter and emits one-cycle step and beat strobes.
- Run control comes from the game FSM: start, pause, stop. Runs entirely in the 104 MHz domain; all strobes are clock enables, not clocks.

Parameters:
- POS_W, 16, width of position / song_length.
- STEPS_PER_BEAT, 4, steps per beat_strobe; must be ≥1.
- TPS_W, 16, width of ticks_per_step.

Ports:
- clock_104mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tick_in  in  1  divided tick level from clock divider.
- start  in  1  start / resume request, level, sampled per cycle.
- pause  in  1  pause request.
- stop  in  1  abort and clear.
- ticks_per_step  in  TPS_W  tick edges per step; latched on start from IDLE.
- song_length  in  POS_W  number of steps in song; latched on start from IDLE.
- position  out  POS_W  current step index.
- step_strobe  out  1  one-cycle pulse per step advance.
- beat_strobe  out  1  one-cycle pulse on beat boundary.
- running  out  1  high in RUNNING.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, reset_n=0) values:
  - All outputs 0; state IDLE.
  - Internal tick counter, step-in-beat counter, latched config and edge-detect flops all 0.
- Edge detect: tick_d <= tick_s. tick_pulse = tick_s & ~tick_d. tick_s is tick_in, or its synchronised copy (see Optional Feature).
- States: IDLE, RUNNING, PAUSED, DONE. Priority in every state: stop > pause > start.
- IDLE:
  - start → RUNNING.
  - Latch tps = max(ticks_per_step, 1) and len = song_length.
  - Clear tick counter, position and beat counter.
  - If song_length == 0, start → DONE directly; no strobes.
- RUNNING:
  - On tick_pulse, tick counter increments.
  - When counter == tps-1 and tick_pulse: counter → 0 and step_strobe=1 next cycle.
  - If position == len-1: go to DONE, position holds len-1. Otherwise position+1.
  - beat counter increments per step, wraps at STEPS_PER_BEAT-1. beat_strobe asserted in the same cycle as the step_strobe whose step wraps it.
  - First beat_strobe on step STEPS_PER_BEAT.
  - pause → PAUSED. start ignored.
- PAUSED:
  - Tick pulses ignored; counters frozen; position held.
  - start → RUNNING, resumes mid-step with tick counter preserved.
  - tick_d still tracks, so a level held across the pause does not produce a spurious edge.
- DONE:
  - done=1, position held.
  - start → restart as from IDLE (re-latch config). pause ignored.
- stop from any state:
  - → IDLE next cycle; position, counters, done, running cleared.
  - Strobes suppressed in the cycle stop is sampled.
- Latency: step_strobe is registered. It rises 1 cycle after the clock edge that first samples the completing tick_in high (macro off), or 3 cycles (macro on).
- Config inputs are ignored except at the latch points.
- position never wraps; saturates at len-1 in DONE.
- Reset asserted mid-song: immediate clear, no strobe glitch.

Optional Feature:
- TICK_SYNC_EN
  - Defined: tick_in passes through a 2-flop synchroniser before edge detect; adds 2 cycles of latency. Used when the tick comes from an unrelated domain.
  - Undefined: tick_in feeds edge detect directly. Legal only because the divider output is generated from clock_104mhz.

Decomposition:
- Package song_timer_pkg:
  - state enum (IDLE/RUNNING/PAUSED/DONE).
  - localparam widths.
  - Beat counter width = clog2(STEPS_PER_BEAT).
- One natural sub-module: tick_edge_detect (optional synchroniser + rising-edge pulse, macro handled inside). FSM and counters stay in song_timer.

Test Plan:
- Reset, then tps=3, len=8, STEPS_PER_BEAT=4, start; 24 tick rising edges → 8 step_strobes, every 3rd edge; beat_strobe on steps 4 and 8; position ends 7, done=1.
- tps=0, len=2, start; 2 edges → step_strobes on every edge (treated as 1); DONE after the 2nd.
- Pause after 1 edge of a tps=3 step, tick_in held high across the pause, 5 edges during pause → no strobes. Resume → next step_strobe after exactly 2 more edges.
- stop and start same cycle while RUNNING at position 5 → IDLE, position 0, running 0, no strobe that cycle.
- Latency check: macro off, step_strobe rises 1 cycle after the completing edge sample; rebuild with TICK_SYNC_EN → 3 cycles.
- len=0 start → done=1 next cycle, position 0, no step_strobe. Async reset_n pulse mid-step → all outputs 0 immediately.
